// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, req/gnt+rvalid memory port, valid/ready output
// Define IFETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   pc, pc_d;
  logic [ADDR_W-1:0]   req_pc, req_pc_d;
  logic                squash, squash_d;
  logic [DATA_W-1:0]   inst_d;
  logic [ADDR_W-1:0]   inst_pc_d;
  logic                inst_valid_d;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      squash     <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      req_pc     <= req_pc_d;
      squash     <= squash_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
      inst_valid <= inst_valid_d;
    end
  end

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    req_pc_d     = req_pc;
    squash_d     = squash;
    inst_d       = inst;
    inst_pc_d    = inst_pc;
    inst_valid_d = inst_valid;
    case (state)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          req_pc_d = pc;
          state_d  = WAIT;
          // The granted request cannot be withdrawn, so its response must be dropped.
          if (redirect) squash_d = 1'b1;
        end
      end
      WAIT: begin
        if (redirect) begin
          if (imem_rvalid) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (squash) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = req_pc;
            inst_valid_d = 1'b1;
            pc_d         = req_pc + STEP;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect || inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect) pc_d = redirect_pc;
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (inst_valid && inst_ready) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == REQ || state == WAIT) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard testbench for instr_fetch_unit
// Main instance uses RESET_PC=0; a second instance checks PC wrap from 32'hFFFFFFFC.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  logic [31:0] w_addr;
  logic        w_req;
  logic        w_gnt;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic        w_valid;
  logic        w_ready;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
  logic [31:0] w_perf_fetch_cnt, w_perf_stall_cnt;
`endif

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst_n),
    .imem_addr(w_addr), .imem_req(w_req), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .inst(w_inst), .inst_pc(w_pc), .inst_valid(w_valid), .inst_ready(w_ready)
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(w_perf_fetch_cnt), .perf_stall_cnt(w_perf_stall_cnt)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  bit          mem_en = 1'b1;
  int          gnt_wait = 0;
  int          rv_lat = 1;
  int          stall = 0;
  int          rv_cnt = 0;
  logic [31:0] rsp_addr = '0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a * 32'd3 + 32'h0010_0000;
  endfunction

  // Instruction memory model: grants after gnt_wait idle cycles, answers rv_lat cycles after grant.
  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rv_cnt = 0;
        stall  = 0;
      end
      if (mem_en) begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        if (rst_n) begin
          if (rv_cnt != 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
              imem_rvalid = 1'b1;
              imem_rdata  = data_of(rsp_addr);
            end
          end
          if (imem_req) begin
            if (stall < gnt_wait) begin
              stall++;
            end else begin
              imem_gnt = 1'b1;
              stall    = 0;
              rsp_addr = imem_addr;
              rv_cnt   = rv_lat;
              exp_q.push_back({imem_addr, data_of(imem_addr)});
            end
          end
        end
      end
    end
  end

  task automatic do_reset(input int gw, input int rl, input logic rdy);
    rst_n = 1'b0;
    redirect = 1'b0;
    inst_ready = rdy;
    gnt_wait = gw;
    rv_lat = rl;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst got %h/%h want 0/0", inst, inst_pc); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    checks++; if (w_addr !== 32'hFFFF_FFFC || w_req !== 1'b0) begin errors++; $display("FAIL reset_wrap_addr got %h/%b want fffffffc/0", w_addr, w_req); end
`ifdef IFETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
  endtask

  task automatic test_basic();
    logic [31:0] exp_pc;
    logic [63:0] e;
    logic [31:0] req_addrs[$];
    logic        prev_req;
    int          n_xfer, n_valid;
    do_reset(0, 1, 1'b1);
    exp_pc = 32'h0; n_xfer = 0; n_valid = 0; prev_req = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (imem_req && !prev_req) req_addrs.push_back(imem_addr);
      prev_req = imem_req;
      if (inst_valid) n_valid++;
      if (inst_valid && inst_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL basic_unexpected got pc %h want none", inst_pc);
        end else begin
          e = exp_q.pop_front();
          if ({inst_pc, inst} !== e || inst_pc !== exp_pc || inst !== data_of(exp_pc)) begin
            errors++; $display("FAIL basic_xfer got %h/%h want %h/%h", inst_pc, inst, exp_pc, data_of(exp_pc));
          end
        end
        exp_pc += 32'd4;
        n_xfer++;
      end
    end
    checks++; if (n_xfer != 10) begin errors++; $display("FAIL basic_count got %0d want 10", n_xfer); end
    checks++; if (n_valid != n_xfer) begin errors++; $display("FAIL basic_valid_cycles got %0d want %0d", n_valid, n_xfer); end
    checks++;
    if (req_addrs.size() < 2) begin
      errors++; $display("FAIL basic_req_addr got %0d requests want >=2", req_addrs.size());
    end else if (req_addrs[0] !== 32'h0 || req_addrs[1] !== 32'h4) begin
      errors++; $display("FAIL basic_req_addr got %h,%h want 0,4", req_addrs[0], req_addrs[1]);
    end
    @(negedge clk);
`ifdef IFETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'd10 || perf_stall_cnt !== 32'd20) begin errors++; $display("FAIL basic_perf got %0d/%0d want 10/20", perf_fetch_cnt, perf_stall_cnt); end
`endif
  endtask

  task automatic test_gnt_stall();
    logic [63:0] e;
    bit          seen;
    do_reset(3, 1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold c%0d got req %b addr %h valid %b want 1/0/0", c, imem_req, imem_addr, inst_valid);
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        seen = 1'b1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        checks++;
        if ({inst_pc, inst} !== e || inst_pc !== 32'h0 || inst !== data_of(32'h0)) begin
          errors++; $display("FAIL stall_xfer got %h/%h want 0/%h", inst_pc, inst, data_of(32'h0));
        end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall_timeout got no transfer want one"); end
  endtask

  task automatic test_hold();
    logic [31:0] v_inst, v_pc;
    logic [63:0] e;
    do_reset(0, 1, 1'b0);
    for (int c = 0; c < 10 && inst_valid !== 1'b1; c++) @(negedge clk);
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL hold_timeout got valid %b want 1", inst_valid); end
    v_inst = inst; v_pc = inst_pc;
    checks++; if (v_pc !== 32'h0 || v_inst !== data_of(32'h0)) begin errors++; $display("FAIL hold_first got %h/%h want 0/%h", v_pc, v_inst, data_of(32'h0)); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (inst !== v_inst || inst_pc !== v_pc || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
        errors++; $display("FAIL hold_stable c%0d got %h/%h v%b req%b want %h/%h v1 req0", c, inst, inst_pc, inst_valid, imem_req, v_inst, v_pc);
      end
    end
    @(negedge clk);
    inst_ready = 1'b1;
    if (inst_valid && inst_ready) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      checks++;
      if ({inst_pc, inst} !== e) begin errors++; $display("FAIL hold_xfer got %h want %h", {inst_pc, inst}, e); end
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++; $display("FAIL hold_next got v%b req%b addr %h want v0 req1 4", inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect();
    logic [63:0] e;
    bit          seen;
    do_reset(0, 3, 1'b0);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL redir_req0 got %b/%h want 1/0", imem_req, imem_addr); end
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h40;
    exp_q.delete();
    @(negedge clk);
    redirect = 1'b0; rv_lat = 1;
    for (int c = 0; c < 2; c++) begin
      checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL redir_wait c%0d got v%b req%b want 0/0", c, inst_valid, imem_req); end
      @(negedge clk);
    end
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL redir_wait_addr got v%b req%b addr %h want 0/1/40", inst_valid, imem_req, imem_addr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== data_of(32'h40) || exp_q.size() != 1) begin
      errors++; $display("FAIL redir_target got v%b %h/%h q%0d want 1 40/%h q1", inst_valid, inst_pc, inst, exp_q.size(), data_of(32'h40));
    end
    redirect = 1'b1; redirect_pc = 32'h100; gnt_wait = 2;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_hold got v%b req%b addr %h want 0/1/100", inst_valid, imem_req, imem_addr);
    end
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0; inst_ready = 1'b1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL redir_req got req%b addr %h want 1/200", imem_req, imem_addr);
    end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        seen = 1'b1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        checks++;
        if ({inst_pc, inst} !== e || inst_pc !== 32'h200) begin
          errors++; $display("FAIL redir_xfer got %h/%h want 200/%h", inst_pc, inst, data_of(32'h200));
        end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL redir_timeout got no transfer want one"); end
  endtask

  task automatic test_wrap();
    do_reset(0, 1, 1'b0);
    @(negedge clk);
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got req%b addr %h want 1/fffffffc", w_req, w_addr); end
    w_gnt = 1'b1;
    @(negedge clk);
    w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'hCAFE_0001;
    @(negedge clk);
    w_rvalid = 1'b0;
    checks++;
    if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_inst !== 32'hCAFE_0001) begin
      errors++; $display("FAIL wrap_inst got v%b %h/%h want 1 fffffffc/cafe0001", w_valid, w_pc, w_inst);
    end
    @(negedge clk);
    checks++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin errors++; $display("FAIL wrap_second got req%b addr %h want 1/0", w_req, w_addr); end
  endtask

  task automatic test_async_reset();
    logic [63:0] e;
    bit          seen;
    do_reset(0, 2, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        seen = 1'b1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        checks++;
        if ({inst_pc, inst} !== e || inst_pc !== 32'h0) begin errors++; $display("FAIL arst_pre got %h/%h want 0/%h", inst_pc, inst, data_of(32'h0)); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL arst_pre_timeout got no transfer want one"); end
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL arst_in_wait got req%b v%b want 0/0", imem_req, inst_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst !== 32'h0 || inst_pc !== 32'h0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL arst_outputs got req%b addr %h inst %h pc %h v%b want all 0", imem_req, imem_addr, inst, inst_pc, inst_valid);
    end
`ifdef IFETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL arst_perf got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
    mem_en = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
        errors++; $display("FAIL arst_late_rvalid c%0d got v%b req%b addr %h want 0/1/0", c, inst_valid, imem_req, imem_addr);
      end
    end
    imem_rvalid = 1'b0;
    mem_en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        seen = 1'b1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        checks++;
        if ({inst_pc, inst} !== e || inst_pc !== 32'h0 || inst !== data_of(32'h0)) begin
          errors++; $display("FAIL arst_post got %h/%h want 0/%h", inst_pc, inst, data_of(32'h0));
        end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL arst_post_timeout got no transfer want one"); end
    @(negedge clk);
`ifdef IFETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'd1) begin errors++; $display("FAIL arst_perf_fetch got %0d want 1", perf_fetch_cnt); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0;
    w_redirect = 1'b0; w_redirect_pc = '0; w_ready = 1'b1;
    test_reset();
    test_basic();
    test_gnt_stall();
    test_hold();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
